pe_feeder: RTL and testbench
============================

PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter N, default 4, number of PE rows fed (lanes).
REQ-002 Parameter WIDTH, default 16, signed operand width per lane.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a tile; honoured only in IDLE.
REQ-006 k_len  input  8  beats per tile; sampled on accepted start.
REQ-007 in_valid  input  1  in_data holds a valid beat.
REQ-008 in_ready  output  1  feeder accepts a beat this cycle.
REQ-009 in_data  input  N*WIDTH  one signed operand per lane; lane i at bits [i*WIDTH +: WIDTH].
REQ-010 feed_a  output  N*WIDTH  skewed operand stream to the PE array row inputs; same lane packing.
REQ-011 pe_clr  output  1  one-cycle accumulator-clear pulse to the PE array.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when the tile has fully drained.
REQ-014 underrun  output  1  sticky gap flag; present only with the Configuration macro.

Function
REQ-015 FSM states IDLE, CLEAR, STREAM, FLUSH, DONE; encoding free.
REQ-016 IDLE -> CLEAR on start=1; start in any other state is ignored.
REQ-017 CLEAR lasts exactly one cycle with pe_clr=1; pe_clr=0 in all other states.
REQ-018 CLEAR -> STREAM when latched k_len>0; CLEAR -> FLUSH when k_len=0.
REQ-019 in_ready=1 only in STREAM; a beat is accepted on in_valid & in_ready.
REQ-020 Lane i is an (i+1)-stage delay line: a beat accepted at edge t appears on feed_a lane i from edge t+1+i, held one cycle.
REQ-021 All delay lines shift every cycle in STREAM and FLUSH; on a STREAM cycle with no accepted beat, signed zero is shifted in on every lane.
REQ-022 In IDLE, CLEAR and DONE the delay lines hold zero and feed_a=0.
REQ-023 An 8-bit beat counter counts accepted beats; STREAM -> FLUSH on the edge accepting beat k_len.
REQ-024 FLUSH shifts zeros for exactly N cycles, then -> DONE; the last beat has then left lane N-1.
REQ-025 DONE lasts one cycle with done=1, then -> IDLE.
REQ-026 Operands pass unmodified; no arithmetic, truncation or sign change.
REQ-027 k_len=255 is supported without counter wrap; the counter clears in CLEAR.

Reset
REQ-028 rst=0 asynchronously forces IDLE, clears all delay lines, the counter and underrun.
REQ-029 During reset: feed_a=0, in_ready=0, pe_clr=0, busy=0, done=0, underrun=0.
REQ-030 Reset asserted mid-tile abandons the tile with no done pulse; operation resumes only after a new start.

Configuration
REQ-031 Macro PE_FEEDER_UNDERRUN_EN defined: underrun port exists, sets on any STREAM cycle with in_valid=0, clears only in CLEAR or on reset.
REQ-032 Macro undefined: underrun port and logic are absent; the rest of the behaviour is unchanged.

Verification
REQ-033 N=4, start, k_len=3, beats {1,2,3,4},{5,6,7,8},{9,10,11,12} back-to-back -> lane0 shows 1,5,9 starting one cycle after the first accept; lane3 shows 4,8,12 three cycles later; done 4 cycles after the last accept.
REQ-034 start with k_len=0 -> pe_clr one cycle, in_ready never high, feed_a stays 0, done exactly 1+4+1 cycles after start.
REQ-035 k_len=2 with one in_valid=0 cycle between beats -> zero bubble on every lane in the matching skewed slot, done delayed by one cycle; with the macro defined, underrun=1 until the next CLEAR.
REQ-036 start pulsed during STREAM and FLUSH -> no state change; exactly one pe_clr and one done per tile.
REQ-037 rst=0 asserted mid-STREAM with nonzero data in flight -> feed_a=0 and busy=0 immediately, no done; next start runs a clean tile.
REQ-038 Lane value 16'h8000 and 16'h7FFF streamed -> identical bit patterns on feed_a with no sign change.

Source files
------------

// File: rtl/pe_feeder.sv
// Skewed operand feeder for an N-row systolic PE array: clears the array, then streams k_len beats with lane i delayed by i+1 cycles.
// Optional sticky underrun flag is built when PE_FEEDER_UNDERRUN_EN is defined.
module pe_feeder #(
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N*WIDTH-1:0]   feed_a,
  output logic                 pe_clr,
  output logic                 busy,
  output logic                 done
`ifdef PE_FEEDER_UNDERRUN_EN
  ,
  output logic                 underrun
`endif
);

  localparam int FW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state_reg;
  logic [7:0]      k_reg;
  logic [7:0]      beat_cnt_reg;
  logic [FW-1:0]   flush_cnt_reg;
  logic            accept;
  logic            shift_en;

  assign accept   = in_valid && in_ready;
  assign shift_en = (state_reg == STREAM) || (state_reg == FLUSH);

  // Outputs are registered alongside each transition so they never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      beat_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      in_ready      <= 1'b0;
      pe_clr        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      pe_clr <= 1'b0;
      done   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= CLEAR;
            k_reg     <= k_len;
            pe_clr    <= 1'b1;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          beat_cnt_reg  <= '0;
          flush_cnt_reg <= '0;
          if (k_reg != 8'd0) begin
            state_reg <= STREAM;
            in_ready  <= 1'b1;
          end else begin
            state_reg <= FLUSH;
          end
        end
        STREAM: begin
          if (in_valid) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
            // Compare before increment so k_len=255 never needs a wrapped count.
            if ((beat_cnt_reg + 8'd1) == k_reg) begin
              state_reg <= FLUSH;
              in_ready  <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_reg == FW'(N - 1)) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + FW'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic signed [WIDTH-1:0] stage_reg [0:gi];

      // Lane gi is gi+1 registers deep; outside STREAM/FLUSH it is held at zero.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int j = 0; j <= gi; j++) stage_reg[j] <= '0;
        end else if (shift_en) begin
          stage_reg[0] <= accept ? in_data[gi*WIDTH +: WIDTH] : '0;
          for (int j = 1; j <= gi; j++) stage_reg[j] <= stage_reg[j-1];
        end else begin
          for (int j = 0; j <= gi; j++) stage_reg[j] <= '0;
        end
      end

      assign feed_a[gi*WIDTH +: WIDTH] = stage_reg[gi];
    end
  endgenerate

`ifdef PE_FEEDER_UNDERRUN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun <= 1'b0;
    end else if (state_reg == CLEAR) begin
      underrun <= 1'b0;
    end else if ((state_reg == STREAM) && !in_valid) begin
      underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Randomized bench for pe_feeder: a cycle-level reference built from a beat-history ring and tile phase counters.
module tb_pe_feeder;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [7:0]     k_len = '0;
  logic           in_valid = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic           in_ready;
  logic [N*W-1:0] feed_a;
  logic           pe_clr;
  logic           busy;
  logic           done;
`ifdef PE_FEEDER_UNDERRUN_EN
  logic           underrun;
`endif

  pe_feeder #(.N(N), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .feed_a   (feed_a),
    .pe_clr   (pe_clr),
    .busy     (busy),
    .done     (done)
`ifdef PE_FEEDER_UNDERRUN_EN
    ,
    .underrun (underrun)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: phase 0 idle, 1 clear, 2 stream, 3 flush, 4 done.
  // hist[] records what entered the skew at each edge; lane i shows the entry from i edges earlier.
  int             m_phase = 0;
  int             m_k = 0;
  int             m_got = 0;
  int             m_fl = 0;
  bit             m_under = 1'b0;
  bit             m_acc = 1'b0;
  int             edge_n = 0;
  logic [N*W-1:0] hist [8];

  initial for (int i = 0; i < 8; i++) hist[i] = '0;

  always @(posedge clk) begin
    logic [N*W-1:0] slot;
    slot = '0;
    edge_n++;
    m_acc = 1'b0;
    if (!rst) begin
      m_phase = 0;
      m_under = 1'b0;
      for (int i = 0; i < 8; i++) hist[i] = '0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_k = int'(k_len); end
        1: begin
          m_under = 1'b0;
          m_got = 0;
          m_fl = 0;
          m_phase = (m_k > 0) ? 2 : 3;
        end
        2: if (in_valid) begin
          slot = in_data;
          m_acc = 1'b1;
          m_got++;
          if (m_got == m_k) m_phase = 3;
        end else begin
          m_under = 1'b1;
        end
        3: begin m_fl++; if (m_fl == N) m_phase = 4; end
        default: m_phase = 0;
      endcase
    end
    hist[edge_n % 8] = slot;
  end

  function automatic logic [N*W-1:0] exp_feed();
    logic [N*W-1:0] v;
    logic [N*W-1:0] h;
    v = '0;
    if (m_phase == 2 || m_phase == 3) begin
      for (int i = 0; i < N; i++) begin
        h = hist[((edge_n - i) % 8 + 8) % 8];
        v[i*W +: W] = h[i*W +: W];
      end
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst) begin
        check("feed_a_rst", feed_a, '0);
        check("in_ready_rst", {63'd0, in_ready}, '0);
        check("pe_clr_rst", {63'd0, pe_clr}, '0);
        check("busy_rst", {63'd0, busy}, '0);
        check("done_rst", {63'd0, done}, '0);
`ifdef PE_FEEDER_UNDERRUN_EN
        check("underrun_rst", {63'd0, underrun}, '0);
`endif
      end else begin
        check("feed_a", feed_a, exp_feed());
        check("in_ready", {63'd0, in_ready}, {63'd0, m_phase == 2});
        check("pe_clr", {63'd0, pe_clr}, {63'd0, m_phase == 1});
        check("busy", {63'd0, busy}, {63'd0, m_phase != 0});
        check("done", {63'd0, done}, {63'd0, m_phase == 4});
`ifdef PE_FEEDER_UNDERRUN_EN
        check("underrun", {63'd0, underrun}, {63'd0, m_under});
`endif
      end
    end
  end

  logic [N*W-1:0] beat_q [$];

  function automatic logic [N*W-1:0] rand_beat();
    logic [N*W-1:0] v;
    int sel;
    for (int i = 0; i < N; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      v[i*W +: W] = 16'h8000;
      else if (sel == 1) v[i*W +: W] = 16'h7FFF;
      else if (sel == 2) v[i*W +: W] = '0;
      else               v[i*W +: W] = W'($urandom);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tile(input int k, input int valid_pct, input int gap_at,
                          input bit poke, input int rst_at);
    int n;
    start = 1'b1;
    k_len = 8'(k);
    tick();
    start = 1'b0;
    n = 0;
    while (m_phase != 0 && n < 2000) begin
      in_valid = ($urandom_range(0, 99) < valid_pct) && (n != gap_at);
      in_data  = (beat_q.size() > 0) ? beat_q[0] : rand_beat();
      k_len    = 8'($urandom);
      if (poke && $urandom_range(0, 2) == 0) start = 1'b1;
      if (n == rst_at) begin
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        start = 1'b0;
        break;
      end
      tick();
      if (m_acc && beat_q.size() > 0) void'(beat_q.pop_front());
      start = 1'b0;
      n++;
    end
    if (n >= 2000) check("tile_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
    beat_q.delete();
    tick();
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    #1;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Three back-to-back beats.
    beat_q.push_back(64'h0004_0003_0002_0001);
    beat_q.push_back(64'h0008_0007_0006_0005);
    beat_q.push_back(64'h000C_000B_000A_0009);
    run_tile(3, 100, -1, 1'b0, -1);

    // Empty tile.
    run_tile(0, 100, -1, 1'b0, -1);

    // One bubble between two beats.
    run_tile(2, 100, 2, 1'b0, -1);

    // Start pulses while busy must be ignored.
    run_tile(5, 100, -1, 1'b1, -1);

    // Extreme signed values pass through untouched.
    beat_q.push_back(64'h7FFF_8000_7FFF_8000);
    beat_q.push_back(64'h8000_7FFF_8000_7FFF);
    run_tile(2, 100, -1, 1'b0, -1);

    // Reset mid-stream with data in flight, then a clean tile.
    run_tile(8, 100, -1, 1'b0, 4);
    run_tile(3, 100, -1, 1'b0, -1);

    // Longest tile.
    run_tile(255, 100, -1, 1'b0, -1);

    for (int t = 0; t < 30; t++) begin
      run_tile($urandom_range(0, 12), $urandom_range(40, 100), -1,
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
